// File: rtl/switch_box_config_loader.sv
`default_nettype none
// ============================================================================
//  Module   : switch_box_config_loader
//  Purpose  : Loads the switch-box / connection-block configuration scan
//             chain. Accepts bitstream words over a valid/ready handshake,
//             serialises them LSB-first onto the chain, then issues a single
//             latch strobe so every switch point updates at once.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            : clock, all state changes on the rising edge
//    rst_n          : asynchronous active-low reset
//    start_i        : one-cycle load request (ignored while busy)
//    abort_i        : synchronous cancel, overrides every other input
//    in_data_i      : bitstream word
//    in_valid_i     : in_data_i valid
//    in_ready_o     : loader accepts a word this cycle
//    cfg_shift_en_o : chain shifts by one bit this cycle
//    cfg_bit_o      : serial bit into the chain (valid with cfg_shift_en_o)
//    cfg_latch_o    : one-cycle strobe copying chain into active config
//    busy_o         : load in progress
//    done_o         : high from a successful latch until next start/abort
// ============================================================================
module switch_box_config_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              cfg_shift_en_o,
    output logic              cfg_bit_o,
    output logic              cfg_latch_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int c_REM_W = $clog2(CHAIN_LEN + 1);
    localparam int c_WC_W  = $clog2(WORD_W + 1);
    // Common width so the min(WORD_W, remaining) compare never truncates,
    // whichever of the two counters is wider.
    localparam int c_CMP_W = (c_REM_W > c_WC_W) ? c_REM_W : c_WC_W;

    localparam logic [c_REM_W-1:0] c_REM_INIT = c_REM_W'(CHAIN_LEN);
    localparam logic [c_REM_W-1:0] c_REM_ONE  = c_REM_W'(1);
    localparam logic [c_WC_W-1:0]  c_WC_ONE   = c_WC_W'(1);
    localparam logic [c_WC_W-1:0]  c_WC_FULL  = c_WC_W'(WORD_W);
    localparam logic [c_CMP_W-1:0] c_WORD_CMP = c_CMP_W'(WORD_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q,    state_d;
    logic [WORD_W-1:0]   shreg_q,    shreg_d;
    logic [c_REM_W-1:0]  rem_q,      rem_d;
    logic [c_WC_W-1:0]   wcnt_q,     wcnt_d;
    logic                rdy_q,      rdy_d;
    logic                shift_en_q, shift_en_d;
    logic                bit_q,      bit_d;
    logic                latch_q,    latch_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;

    logic                w_hs;
    logic [c_CMP_W-1:0]  w_rem_ext;
    logic [c_WC_W-1:0]   w_word_bits;

    // abort masks the ready so a word presented alongside it is never taken
    assign in_ready_o = rdy_q & ~abort_i;
    assign w_hs       = in_valid_i & in_ready_o;

    // Bits to shift from the word being captured: a full word, or only the
    // low remainder bits when the chain ends partway through it.
    assign w_rem_ext   = c_CMP_W'(rem_q);
    assign w_word_bits = (w_rem_ext >= c_WORD_CMP) ? c_WC_FULL : c_WC_W'(w_rem_ext);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        done_d  = done_q;
        rdy_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    rem_d   = c_REM_INIT;
                    done_d  = 1'b0;
                    rdy_d   = 1'b1;
                end
            end
            ST_LOAD: begin
                // Arriving here from SHIFT, ready is low for one turnaround
                // cycle; it rises on the following cycle and stays up until
                // the source presents a word.
                if (w_hs) begin
                    shreg_d = in_data_i;
                    wcnt_d  = w_word_bits;
                    state_d = ST_SHIFT;
                end else begin
                    rdy_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                shreg_d = shreg_q >> 1;
                rem_d   = rem_q - c_REM_ONE;
                wcnt_d  = wcnt_q - c_WC_ONE;
                if (wcnt_q == c_WC_ONE) begin
                    state_d = (rem_q == c_REM_ONE) ? ST_LATCH : ST_LOAD;
                end
            end
            ST_LATCH: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_i) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            rdy_d   = 1'b0;
        end

        // Outputs are registered from the next state so they line up with it.
        shift_en_d = (state_d == ST_SHIFT);
        bit_d      = shift_en_d & shreg_d[0];
        latch_d    = (state_d == ST_LATCH);
        busy_d     = (state_d == ST_LOAD) || (state_d == ST_SHIFT) ||
                     (state_d == ST_LATCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            rem_q      <= '0;
            wcnt_q     <= '0;
            rdy_q      <= 1'b0;
            shift_en_q <= 1'b0;
            bit_q      <= 1'b0;
            latch_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            rem_q      <= rem_d;
            wcnt_q     <= wcnt_d;
            rdy_q      <= rdy_d;
            shift_en_q <= shift_en_d;
            bit_q      <= bit_d;
            latch_q    <= latch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cfg_shift_en_o = shift_en_q;
    assign cfg_bit_o      = bit_q;
    assign cfg_latch_o    = latch_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule
`default_nettype wire
